signal_change_monitor: RTL
==========================

SIGNAL_CHANGE_MONITOR -- requirements
Module: signal_change_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 6, width of the monitored bus (the LED bus).
REQ-002 SHALL have parameter TS_WIDTH, default 32, width of the cycle timestamp.
REQ-003 SHALL have parameter DEPTH, default 16, event FIFO entries, power of two, >= 2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 10800 (200 us at 54 MHz); 0 disables the watchdog.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port sig_in  input  WIDTH  monitored bus, synchronous to clk.
REQ-008 SHALL have port ev_valid  output  1  FIFO head holds an event.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts the head event.
REQ-010 SHALL have port ev_value  output  WIDTH  new bus value of the head event.
REQ-011 SHALL have port ev_prev  output  WIDTH  bus value before the change.
REQ-012 SHALL have port ev_time  output  TS_WIDTH  timestamp of the change.
REQ-013 SHALL have port ev_first  output  1  head event is the first sample after reset (ev_prev is invalid).
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port overflow  output  1  sticky: at least one event was dropped.
REQ-016 SHALL have port drop_count  output  8  dropped-event count, saturating at 255.
REQ-017 SHALL have port timed_out  output  1  sticky: no change for TIMEOUT_CYCLES cycles.

Function
REQ-018 SHALL run a free-running counter ts that is 0 in the first cycle after reset, increments every cycle and wraps at 2^TS_WIDTH.
REQ-019 SHALL hold a register last_q with the previous sig_in sample, plus a first_pending flag that is set by reset.
REQ-020 SHALL generate an event at a rising edge when first_pending=1, or when sig_in != last_q.
REQ-021 SHALL store each event as {ts, sig_in, last_q, first_pending}, and SHALL then clear first_pending and load last_q with sig_in, whether or not the event was stored.
REQ-022 SHALL make an event written at edge N visible on ev_valid/ev_* after edge N when the FIFO was empty: one cycle of latency, with no bypass path.
REQ-023 SHALL pop the head at an edge when ev_valid and ev_ready are both 1; ev_* SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-024 SHALL, with push and pop at the same edge, accept both (also when full); level is unchanged.
REQ-025 SHALL, with push while full and no pop, drop the event, set overflow, and increment drop_count (saturating at 255); FIFO contents are unchanged.
REQ-026 SHALL ignore a pop while empty (no underflow) and keep level >= 0 and <= DEPTH.
REQ-027 SHALL wrap the FIFO read and write pointers modulo DEPTH, and SHALL distinguish full from empty by an extra pointer bit.
REQ-028 SHALL clear the watchdog counter on every event; otherwise it increments. When it reaches TIMEOUT_CYCLES it SHALL set timed_out, which stays set until reset; the counter SHALL stop at the limit.
REQ-029 SHALL force timed_out to 0 at all times when TIMEOUT_CYCLES=0.

Reset
REQ-030 SHALL, while rst=1 at an edge, set: ts=0, FIFO empty, level=0, ev_valid=0, ev_* = 0, overflow=0, drop_count=0, timed_out=0, watchdog counter=0, first_pending=1, last_q=0.
REQ-031 SHALL, on rst asserted mid-operation, discard all queued events, take no push or pop at that edge, and record the first sample after rst falls as an event with ev_first=1.

Structure
REQ-032 SHALL place the event record typedef {time, value, prev, first} and the default parameter constants in shared package monitor_pkg.
REQ-033 SHALL implement storage as the sub-module sync_fifo (parametrised data width and depth, with valid/ready read port, level output and full output); change detection, timestamp and watchdog SHALL stay in the top level.

Verification
REQ-034 SHALL cover: reset release with sig_in=6'b000000 held -> exactly one event, ev_first=1, ev_value=0, ev_time=0.
REQ-035 SHALL cover: ev_ready=1, sig_in 0->6'b000001 at ts=10 -> event with value 000001, prev 000000, time 10, ev_first=0, ev_valid one cycle after the edge.
REQ-036 SHALL cover: DEPTH=16, ev_ready=0, sig_in toggling every cycle for 20 cycles -> level=16, overflow=1, drop_count=5 (16 stored including the first event).
REQ-037 SHALL cover: FIFO full, a change applied with ev_ready=1 at the same edge -> level stays 16, the new event is stored, drop_count unchanged.
REQ-038 SHALL cover: TIMEOUT_CYCLES=100, sig_in constant after the first event -> timed_out=1 exactly 100 cycles after that event, staying 1 across later changes until rst.
REQ-039 SHALL cover: rst asserted with 5 queued events -> level=0 and ev_valid=0 on the next cycle; sig_in=6'b101010 after release -> a single event with ev_first=1 and value 101010.

Source files
------------

// File: rtl/monitor_pkg.sv
// ============================================================================
// Module      : monitor_pkg
// Description : Shared defaults and event record layout for the bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package monitor_pkg;

    localparam int c_DEF_WIDTH          = 6;
    localparam int c_DEF_TS_WIDTH       = 32;
    localparam int c_DEF_DEPTH          = 16;
    localparam int c_DEF_TIMEOUT_CYCLES = 10800;
    localparam int c_DROP_COUNT_W       = 8;

    // Record layout at the default widths; the top mirrors this field order
    // for its own parameterised widths.
    typedef struct packed {
        logic [c_DEF_TS_WIDTH-1:0] ts;
        logic [c_DEF_WIDTH-1:0]    value;
        logic [c_DEF_WIDTH-1:0]    prev;
        logic                      first;
    } mon_event_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with valid/ready read port, registered head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_valid,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_full,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]       r_wr_ptr_q;
    logic [c_AW:0]       w_wr_ptr_d;
    logic [c_AW:0]       r_rd_ptr_q;
    logic [c_AW:0]       w_rd_ptr_d;
    logic [DATA_W-1:0]   r_mem_q [DEPTH];
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    always_comb begin
        w_empty    = (r_wr_ptr_q == r_rd_ptr_q);
        w_full     = (r_wr_ptr_q[c_AW] != r_rd_ptr_q[c_AW]) &&
                     (r_wr_ptr_q[c_AW-1:0] == r_rd_ptr_q[c_AW-1:0]);
        w_pop      = !w_empty && i_rd_ready;
        w_push     = i_wr_valid && (!w_full || w_pop);
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_q[r_wr_ptr_q[c_AW-1:0]] <= i_wr_data;
        end
    end

    assign o_full     = w_full;
    assign o_rd_valid = !w_empty;
    assign o_rd_data  = w_empty ? '0 : r_mem_q[r_rd_ptr_q[c_AW-1:0]];
    assign o_level    = r_wr_ptr_q - r_rd_ptr_q;

endmodule

`default_nettype wire

// File: rtl/signal_change_monitor.sv
// ============================================================================
// Module      : signal_change_monitor
// Description : Timestamps every change of a bus into an event FIFO, with
//               overflow accounting and an inactivity watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signal_change_monitor
    import monitor_pkg::*;
#(
    parameter int WIDTH          = c_DEF_WIDTH,
    parameter int TS_WIDTH       = c_DEF_TS_WIDTH,
    parameter int DEPTH          = c_DEF_DEPTH,
    parameter int TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            sig_in,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [WIDTH-1:0]            ev_value,
    output logic [WIDTH-1:0]            ev_prev,
    output logic [TS_WIDTH-1:0]         ev_time,
    output logic                        ev_first,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic [c_DROP_COUNT_W-1:0]   drop_count,
    output logic                        timed_out
);

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [WIDTH-1:0]    value;
        logic [WIDTH-1:0]    prev;
        logic                first;
    } event_t;

    localparam int c_EV_W = $bits(event_t);

    logic [TS_WIDTH-1:0]       r_ts_q;
    logic [TS_WIDTH-1:0]       w_ts_d;
    logic [WIDTH-1:0]          r_last_q;
    logic [WIDTH-1:0]          w_last_d;
    logic                      r_first_q;
    logic                      w_first_d;
    logic                      r_overflow_q;
    logic                      w_overflow_d;
    logic [c_DROP_COUNT_W-1:0] r_drop_count_q;
    logic [c_DROP_COUNT_W-1:0] w_drop_count_d;

    logic                      w_event;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_drop;
    logic                      w_fifo_full;
    logic                      w_fifo_valid;
    event_t                    w_wr_ev;
    event_t                    w_rd_ev;

    always_comb begin
        w_event  = r_first_q || (sig_in != r_last_q);
        w_push   = w_event && !rst;
        w_pop    = w_fifo_valid && ev_ready;
        // A pop at the same edge frees the slot, so only unpopped-full drops.
        w_drop   = w_push && w_fifo_full && !w_pop;

        w_wr_ev.ts    = r_ts_q;
        w_wr_ev.value = sig_in;
        w_wr_ev.prev  = r_last_q;
        w_wr_ev.first = r_first_q;

        w_ts_d         = r_ts_q + 1'b1;
        w_last_d       = sig_in;
        w_first_d      = 1'b0;
        w_overflow_d   = r_overflow_q || w_drop;
        w_drop_count_d = r_drop_count_q;
        if (w_drop && (r_drop_count_q != {c_DROP_COUNT_W{1'b1}})) begin
            w_drop_count_d = r_drop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts_q         <= '0;
            r_last_q       <= '0;
            r_first_q      <= 1'b1;
            r_overflow_q   <= 1'b0;
            r_drop_count_q <= '0;
        end else begin
            r_ts_q         <= w_ts_d;
            r_last_q       <= w_last_d;
            r_first_q      <= w_first_d;
            r_overflow_q   <= w_overflow_d;
            r_drop_count_q <= w_drop_count_d;
        end
    end

    sync_fifo #(
        .DATA_W (c_EV_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_valid (w_push),
        .i_wr_data  (w_wr_ev),
        .o_full     (w_fifo_full),
        .o_rd_valid (w_fifo_valid),
        .i_rd_ready (ev_ready),
        .o_rd_data  (w_rd_ev),
        .o_level    (level)
    );

    assign ev_valid   = w_fifo_valid;
    assign ev_value   = w_rd_ev.value;
    assign ev_prev    = w_rd_ev.prev;
    assign ev_time    = w_rd_ev.ts;
    assign ev_first   = w_rd_ev.first;
    assign overflow   = r_overflow_q;
    assign drop_count = r_drop_count_q;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            localparam int c_WD_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);

            logic [c_WD_W-1:0] r_wd_q;
            logic [c_WD_W-1:0] w_wd_d;
            logic              r_timed_out_q;
            logic              w_timed_out_d;

            // Counter parks at the limit; the flag rises on the edge it lands there.
            always_comb begin
                w_wd_d = r_wd_q;
                if (w_event) begin
                    w_wd_d = '0;
                end else if (r_wd_q != c_WD_LIMIT) begin
                    w_wd_d = r_wd_q + 1'b1;
                end
                w_timed_out_d = r_timed_out_q || (w_wd_d == c_WD_LIMIT);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wd_q        <= '0;
                    r_timed_out_q <= 1'b0;
                end else begin
                    r_wd_q        <= w_wd_d;
                    r_timed_out_q <= w_timed_out_d;
                end
            end

            assign timed_out = r_timed_out_q;
        end else begin : g_no_watchdog
            assign timed_out = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire
